// File: rtl/plot_arbiter.sv
// Shares the VGA adapter plot port between four round-robin player requesters and a
// full-screen clear sweep that always takes priority over player plots.
module plot_arbiter #(
    parameter int unsigned X_MAX        = 160,
    parameter int unsigned Y_MAX        = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
    parameter logic [2:0]  P1_COLOUR    = 3'b001,
    parameter logic [2:0]  P2_COLOUR    = 3'b010,
    parameter logic [2:0]  P3_COLOUR    = 3'b100,
    parameter logic [2:0]  P4_COLOUR    = 3'b110
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [59:0] pos,
    output logic [3:0]  ack,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        clear_done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    localparam logic [7:0] XLimit = 8'(X_MAX);
    localparam logic [6:0] YLimit = 7'(Y_MAX);
    localparam logic [7:0] XLast  = 8'(X_MAX - 1);
    localparam logic [6:0] YLast  = 7'(Y_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPlot,
        StClear,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic [3:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [14:0] pos_arr [4];
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [2:0]  sel_colour;
    logic        sel_in_range;
    logic        sweep_last;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pos_arr[i] = pos[15*i +: 15];
        end
    end

    // Round-robin search starting just after the last granted player, wrapping mod 4.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_x = pos_arr[grant_idx][14:7];
        sel_y = pos_arr[grant_idx][6:0];
        unique case (grant_idx)
            2'd0: sel_colour = P1_COLOUR;
            2'd1: sel_colour = P2_COLOUR;
            2'd2: sel_colour = P3_COLOUR;
            2'd3: sel_colour = P4_COLOUR;
        endcase
        sel_in_range = (sel_x < XLimit) && (sel_y < YLimit);
    end

    // During the sweep x_q/y_q double as the raster counters.
    assign sweep_last = (x_q == XLast) && (y_q == YLast);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= 2'd3;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                end else if (grant_found) begin
                    state_d = StPlot;
                end
            end
            StPlot:  state_d = StIdle;
            StClear: begin
                if (sweep_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d   = last_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        ack_d    = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    x_d      = '0;
                    y_d      = '0;
                    colour_d = CLEAR_COLOUR;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                end else if (grant_found) begin
                    x_d              = sel_x;
                    y_d              = sel_y;
                    colour_d         = sel_colour;
                    // Off-screen positions are still acknowledged so the requester moves on.
                    plot_d           = sel_in_range;
                    ack_d[grant_idx] = 1'b1;
                    last_d           = grant_idx;
                end
            end
            StClear: begin
                if (sweep_last) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    plot_d = 1'b1;
                    if (x_q == XLast) begin
                        x_d = '0;
                        y_d = y_q + 7'd1;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign ack        = ack_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

`ifndef SYNTHESIS
    ack_onehot: assert property (@(posedge CLOCK_50) disable iff (reset) $onehot0(ack_q));
    no_plot_idle_done: assert property (@(posedge CLOCK_50) disable iff (reset)
        (state_q == StIdle || state_q == StDone) |-> !plot_q);
`endif

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: stimulus pushes expected plot/ack/done events,
// a negedge monitor pops and compares whenever the DUT drives any of them.
module tb_plot_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [59:0] pos = '0;
    logic [3:0]  ack;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       busy;
        logic       done;
        logic       chk_xy;
    } ev_t;

    ev_t exp_q[$];

    plot_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req        (req),
        .pos        (pos),
        .ack        (ack),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Monitor: every cycle with a plot, ack or done must match the next expected event.
    ev_t mon_exp;
    logic mon_bad;
    always @(negedge CLOCK_50) begin
        if (ack !== 4'b0000 || plot !== 1'b0 || clear_done !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got ack=%b plot=%b x=%0d y=%0d col=%b done=%b, want none",
                         ack, plot, x, y, colour, clear_done);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_bad = (ack !== mon_exp.ack) || (plot !== mon_exp.plot) ||
                          (clear_busy !== mon_exp.busy) || (clear_done !== mon_exp.done);
                if (mon_exp.chk_xy && (x !== mon_exp.x || y !== mon_exp.y || colour !== mon_exp.colour))
                    mon_bad = 1'b1;
                if (mon_bad) begin
                    failures++;
                    $display("FAIL scoreboard_event: got ack=%b plot=%b x=%0d y=%0d col=%b busy=%b done=%b, want ack=%b plot=%b x=%0d y=%0d col=%b busy=%b done=%b",
                             ack, plot, x, y, colour, clear_busy, clear_done,
                             mon_exp.ack, mon_exp.plot, mon_exp.x, mon_exp.y, mon_exp.colour,
                             mon_exp.busy, mon_exp.done);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        clear_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_pos(input int idx, input logic [7:0] px, input logic [6:0] py);
        pos[15*idx +: 15] = {px, py};
    endtask

    task automatic push_grant(input logic [3:0] a, input logic p, input logic [7:0] px,
                              input logic [6:0] py, input logic [2:0] c);
        exp_q.push_back('{ack: a, plot: p, x: px, y: py, colour: c, busy: 1'b0, done: 1'b0,
                          chk_xy: 1'b1});
    endtask

    task automatic push_pixels(input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back('{ack: 4'b0000, plot: 1'b1, x: 8'(i % 160), y: 7'(i / 160),
                              colour: 3'b000, busy: 1'b1, done: 1'b0, chk_xy: 1'b1});
        end
    endtask

    task automatic push_done();
        exp_q.push_back('{ack: 4'b0000, plot: 1'b0, x: 8'd0, y: 7'd0, colour: 3'b000,
                          busy: 1'b0, done: 1'b1, chk_xy: 1'b0});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (clear_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("clear_done_seen", {31'd0, clear_done}, 32'd1);
    endtask

    task automatic wait_ack(input int idx, input int budget);
        int n = 0;
        while (ack[idx] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("ack_seen", {31'd0, ack[idx]}, 32'd1);
    endtask

    initial begin
        // Reset state.
        do_reset();
        check("rst_x", {24'd0, x}, 32'd0);
        check("rst_y", {25'd0, y}, 32'd0);
        check("rst_colour", {29'd0, colour}, 32'd0);
        check("rst_plot", {31'd0, plot}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, clear_busy}, 32'd0);
        check("rst_done", {31'd0, clear_done}, 32'd0);

        // Single grant, one-cycle latency.
        set_pos(0, 8'd10, 7'd20);
        push_grant(4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
        req = 4'b0001;
        tick();
        check("single_ack", {28'd0, ack}, 32'h1);
        check("single_plot", {31'd0, plot}, 32'd1);
        check("single_x", {24'd0, x}, 32'd10);
        check("single_y", {25'd0, y}, 32'd20);
        req = 4'b0000;
        tick();
        check("single_ack_drop", {28'd0, ack}, 32'd0);
        check("single_plot_drop", {31'd0, plot}, 32'd0);
        tick();

        // Round-robin fairness with all four requesting.
        do_reset();
        set_pos(0, 8'd1, 7'd2);
        set_pos(1, 8'd3, 7'd4);
        set_pos(2, 8'd5, 7'd6);
        set_pos(3, 8'd159, 7'd119);
        push_grant(4'b0001, 1'b1, 8'd1, 7'd2, 3'b001);
        push_grant(4'b0010, 1'b1, 8'd3, 7'd4, 3'b010);
        push_grant(4'b0100, 1'b1, 8'd5, 7'd6, 3'b100);
        push_grant(4'b1000, 1'b1, 8'd159, 7'd119, 3'b110);
        push_grant(4'b0001, 1'b1, 8'd1, 7'd2, 3'b001);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_ack", {28'd0, ack}, 32'(1 << (g % 4)));
            if (g == 4) req = 4'b0000;
            tick();
            check("rr_gap", {28'd0, ack}, 32'd0);
        end

        // Clear beats pending requests; players served afterwards from player 1.
        do_reset();
        set_pos(0, 8'd10, 7'd20);
        set_pos(1, 8'd30, 7'd40);
        push_pixels(19200);
        push_done();
        push_grant(4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
        push_grant(4'b0010, 1'b1, 8'd30, 7'd40, 3'b010);
        clear_req = 1'b1;
        req = 4'b0011;
        tick();
        clear_req = 1'b0;
        check("clr_busy", {31'd0, clear_busy}, 32'd1);
        check("clr_first_xy", {17'd0, x, y}, 32'd0);
        wait_done(19300);
        check("clr_done_busy", {31'd0, clear_busy}, 32'd0);
        check("clr_done_plot", {31'd0, plot}, 32'd0);
        wait_ack(0, 4);
        req = 4'b0010;
        wait_ack(1, 4);
        req = 4'b0000;
        tick();

        // Off-screen position: ack without plot.
        do_reset();
        set_pos(1, 8'd200, 7'd5);
        push_grant(4'b0010, 1'b0, 8'd200, 7'd5, 3'b010);
        req = 4'b0010;
        tick();
        check("oob_ack", {28'd0, ack}, 32'h2);
        check("oob_plot", {31'd0, plot}, 32'd0);
        req = 4'b0000;
        tick();

        // Reset mid-sweep aborts with no done and restores the pointer.
        set_pos(0, 8'd10, 7'd20);
        push_grant(4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
        req = 4'b0001;
        wait_ack(0, 4);
        req = 4'b0000;
        tick();
        push_pixels(500);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (499) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_plot", {31'd0, plot}, 32'd0);
        check("abort_xy", {17'd0, x, y}, 32'd0);
        check("abort_busy", {31'd0, clear_busy}, 32'd0);
        check("abort_done", {31'd0, clear_done}, 32'd0);
        repeat (3) tick();
        push_grant(4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
        req = 4'b0011;
        tick();
        check("abort_ptr_ack", {28'd0, ack}, 32'h1);
        req = 4'b0000;
        tick();
        tick();

        // Held clear_req restarts the sweep after one IDLE cycle.
        do_reset();
        push_pixels(19200);
        push_done();
        push_pixels(19200);
        push_done();
        clear_req = 1'b1;
        wait_done(19300);
        tick();
        check("held_idle_plot", {31'd0, plot}, 32'd0);
        check("held_idle_busy", {31'd0, clear_busy}, 32'd0);
        tick();
        check("held_restart_busy", {31'd0, clear_busy}, 32'd1);
        check("held_restart_xy", {17'd0, x, y}, 32'd0);
        clear_req = 1'b0;
        wait_done(19300);
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA adapter plot port (160x120, 3-bit colour) between four player trail requesters and a full-screen clear engine.
- Players are granted round-robin. A clear has strict priority and sweeps every pixel with a background colour.
- Sits between the game logic (player positions) and vga_adapter. It replaces the free-running player draw sequencer.

Parameters:
- X_MAX, 160, horizontal pixel count; valid x is 0..X_MAX-1
- Y_MAX, 120, vertical pixel count; valid y is 0..Y_MAX-1
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep
- P1_COLOUR, 3'b001, colour for requester 0
- P2_COLOUR, 3'b010, colour for requester 1
- P3_COLOUR, 3'b100, colour for requester 2
- P4_COLOUR, 3'b110, colour for requester 3

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  4  per-player plot request; bit i is player i+1; held high until ack[i]
- pos  in  60  packed positions {p4,p3,p2,p1}; each 15 bits = {x[7:0], y[6:0]}
- ack  out  4  one-cycle grant pulse per player
- clear_req  in  1  request a full-screen clear; sampled level
- clear_busy  out  1  high while the sweep is in progress
- clear_done  out  1  one-cycle pulse after the last clear pixel
- x  out  8  registered plot x
- y  out  7  registered plot y
- colour  out  3  registered plot colour
- plot  out  1  registered write enable to vga_adapter

Behaviour:
- Reset:
  - state=IDLE; x=0, y=0, colour=0, plot=0, ack=0, clear_busy=0, clear_done=0.
  - Round-robin pointer last=3, so player 1 is checked first.
  - Reset asserted mid-sweep aborts the sweep immediately. No clear_done is pulsed.
- States: IDLE, PLOT, CLEAR, DONE.
- IDLE, evaluated on each edge in priority order:
  - clear_req=1: go to CLEAR. Load sweep counters cx=0, cy=0. Set clear_busy=1.
  - else if any req bit is high: choose the first set bit searching from (last+1) mod 4 upward with wrap. Register that player's x/y and colour. Set last to the chosen index. Go to PLOT.
  - else: stay in IDLE with plot=0.
- PLOT (exactly 1 cycle):
  - Outputs plot=1 and ack[i]=1 for the granted player only; return to IDLE.
  - If the latched x>=X_MAX or y>=Y_MAX, plot=0 (write dropped) but ack[i] is still pulsed.
- Latency: req sampled high in IDLE at edge N gives plot/ack high during cycle N+1. Minimum 2 cycles per grant.
- Requester rule: deassert req[i], or present a new pos, on the edge ending the ack cycle. The arbiter re-samples req only in IDLE, so no double grant occurs.
- CLEAR:
  - Each cycle: plot=1, x=cx, y=cy, colour=CLEAR_COLOUR.
  - cx increments; at cx=X_MAX-1, cx wraps to 0 and cy increments.
  - At cx=X_MAX-1 and cy=Y_MAX-1, go to DONE.
  - Total X_MAX*Y_MAX = 19200 plot cycles, in raster order (0,0),(1,0)…(159,0),(0,1)…(159,119).
- DONE (1 cycle): plot=0, clear_busy=0, clear_done=1; return to IDLE.
- Waiting during clear: player reqs held during CLEAR/DONE get no ack. They are served in round-robin order once back in IDLE.
- Clear priority:
  - clear_req rising during PLOT is honoured on the following IDLE cycle and beats all pending reqs.
  - clear_req still high in the IDLE after DONE starts a new sweep (level-sensitive; the requester drops it on clear_done).
- Fairness: with all four reqs continuously re-asserted, grants cycle 1,2,3,4,1… and no player waits more than 4 grants.
- ack is never multi-hot. plot is never high in IDLE or DONE.

Test Plan:
- Reset, then req=4'b0001, p1={x=8'd10,y=7'd20}: plot=1, x=10, y=20, colour=001, ack=0001 exactly one cycle after sampling, then idle.
- req=4'b1111 held, re-asserted after each ack: ack order 0001,0010,0100,1000,0001. Each grant is 2 cycles apart with colours 001,010,100,110.
- clear_req pulse with req=4'b0011 pending: clear_busy for 19200 plot cycles, first pixel (0,0), last (159,119), colour 000. Then clear_done=1 for one cycle, then ack=0001 is next.
- p2={x=8'd200,y=7'd5}, req=4'b0010: ack=0010 pulsed, plot stays 0.
- Reset at cycle 500 of a sweep: next cycle all outputs 0 and state IDLE, with no clear_done. A following req=4'b0001 is granted to player 1 (pointer reset).
- clear_req held high through clear_done: a second sweep starts in the cycle after DONE's IDLE, with cx=0, cy=0 again.
